fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction/data fetch unit: PC, IR, data address register and a
// four-state memory bus sequencer with timeout and sticky bus error.
module fetch_unit #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic              load_pc,
    input  logic              reset_pc,
    input  logic              load_ir,
    input  logic              addr_sel,
    input  logic              load_addr,
    input  logic [DATA_W-1:0] datapath_out,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic              stall,
    output logic              mem_done,
    output logic              bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                is_wr;
    logic [ADDR_W-1:0]   daddr;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [ADDR_W-1:0]   addr_c;
    logic                cmd_valid;
    logic                cmd_write;

    assign cmd_valid = (mem_cmd == 2'b01) || (mem_cmd == 2'b10);
    assign cmd_write = (mem_cmd == 2'b10);
    assign addr_c    = addr_sel ? pc : daddr;

    assign mem_addr  = (state == IDLE) ? addr_c : addr_q;
    assign mem_wdata = (state == IDLE) ? datapath_out : wdata_q;

    // Held low while reset is asserted so a pending command cannot stall the controller
    assign stall = reset && (((state == IDLE) && cmd_valid) || (state == ISSUE) || (state == WAIT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (reset_pc) begin
            pc <= '0;
        end else if (load_pc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            daddr <= '0;
        end else if (load_addr) begin
            daddr <= datapath_out[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir <= '0;
        end else if (load_ir && !stall) begin
            ir <= read_data;
        end
    end

    // Bus sequencer; mem_req/mem_we are set on entry to ISSUE so they are high for that cycle only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            is_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            read_data <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_done  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        is_wr   <= cmd_write;
                        addr_q  <= addr_c;
                        wdata_q <= datapath_out;
                        mem_req <= 1'b1;
                        mem_we  <= cmd_write;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_ready) begin
                        if (!is_wr) begin
                            read_data <= mem_rdata;
                        end
                        mem_done <= 1'b1;
                        state    <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus_err  <= 1'b1;
                        mem_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!cmd_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (reset_pc) begin
                bus_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic        load_pc, reset_pc, load_ir, addr_sel, load_addr;
    logic [15:0] datapath_out, mem_rdata;
    logic        mem_ready;
    logic [8:0]  pc, mem_addr;
    logic [15:0] ir, read_data, mem_wdata;
    logic        mem_req, mem_we, stall, mem_done, bus_err;

    int tests = 0;
    int fails = 0;

    fetch_unit #(.ADDR_W(9), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .load_pc(load_pc),
        .reset_pc(reset_pc), .load_ir(load_ir), .addr_sel(addr_sel),
        .load_addr(load_addr), .datapath_out(datapath_out), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc(pc), .ir(ir), .read_data(read_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req),
        .mem_we(mem_we), .stall(stall), .mem_done(mem_done), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mem_cmd = 2'b01;
        #1;
        tests++; if (pc !== 9'd0) begin fails++; $display("FAIL reset_pc got %0d want 0", pc); end
        tests++; if (ir !== 16'h0 || read_data !== 16'h0) begin fails++; $display("FAIL reset_regs got ir=%h rd=%h want 0", ir, read_data); end
        tests++; if ({mem_req, mem_we, mem_done, stall, bus_err} !== 5'b0) begin fails++; $display("FAIL reset_flags got %b want 00000", {mem_req, mem_we, mem_done, stall, bus_err}); end
        mem_cmd = 2'b00;
        @(negedge clk) reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        reset_pc = 1'b1; tick(); reset_pc = 1'b0;
        load_pc = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        load_pc = 1'b0;
        tests++; if (pc !== 9'd5) begin fails++; $display("FAIL fetch_pc got %0d want 5", pc); end
        addr_sel = 1'b1; mem_cmd = 2'b01;
        #1;
        tests++; if (stall !== 1'b1 || mem_addr !== 9'd5) begin fails++; $display("FAIL fetch_idle got stall=%b addr=%0d want 1/5", stall, mem_addr); end
        tick();
        tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'd5) begin fails++; $display("FAIL fetch_issue got req=%b we=%b addr=%0d want 1/0/5", mem_req, mem_we, mem_addr); end
        load_pc = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hD105;
        tick();
        load_pc = 1'b0;
        tests++; if (pc !== 9'd6 || mem_addr !== 9'd5 || mem_req !== 1'b0 || mem_done !== 1'b0) begin fails++; $display("FAIL fetch_wait got pc=%0d addr=%0d req=%b done=%b want 6/5/0/0", pc, mem_addr, mem_req, mem_done); end
        tick();
        tests++; if (mem_done !== 1'b1 || read_data !== 16'hD105 || stall !== 1'b0) begin fails++; $display("FAIL fetch_done got done=%b rd=%h stall=%b want 1/d105/0", mem_done, read_data, stall); end
        mem_cmd = 2'b00; mem_ready = 1'b0;
        tick();
        tests++; if (mem_done !== 1'b0) begin fails++; $display("FAIL fetch_done_pulse got %b want 0", mem_done); end
        load_ir = 1'b1; tick(); load_ir = 1'b0;
        tests++; if (ir !== 16'hD105) begin fails++; $display("FAIL fetch_ir got %h want d105", ir); end
    endtask

    task automatic test_write();
        datapath_out = 16'h0123; load_addr = 1'b1; tick(); load_addr = 1'b0;
        addr_sel = 1'b0; mem_cmd = 2'b10;
        #1;
        tests++; if (mem_addr !== 9'h123) begin fails++; $display("FAIL write_idle_addr got %h want 123", mem_addr); end
        tick();
        tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'h123 || mem_wdata !== 16'h0123) begin fails++; $display("FAIL write_issue got req=%b we=%b addr=%h wd=%h want 1/1/123/0123", mem_req, mem_we, mem_addr, mem_wdata); end
        datapath_out = 16'hFFFF; mem_ready = 1'b1; mem_rdata = 16'h5555;
        tick();
        tests++; if (mem_wdata !== 16'h0123 || mem_addr !== 9'h123) begin fails++; $display("FAIL write_latched got wd=%h addr=%h want 0123/123", mem_wdata, mem_addr); end
        tick();
        tests++; if (mem_done !== 1'b1 || read_data !== 16'hD105) begin fails++; $display("FAIL write_done got done=%b rd=%h want 1/d105", mem_done, read_data); end
        mem_cmd = 2'b00; mem_ready = 1'b0; tick();
    endtask

    task automatic test_held_cmd();
        int reqs = 0;
        int dones = 0;
        addr_sel = 1'b1; mem_cmd = 2'b01; mem_ready = 1'b1; mem_rdata = 16'hBEEF; load_ir = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (mem_req) reqs++;
            if (mem_done) dones++;
            if (k == 2) begin
                tests++; if (ir !== 16'hD105 || read_data !== 16'hBEEF) begin fails++; $display("FAIL held_ir_stalled got ir=%h rd=%h want d105/beef", ir, read_data); end
            end
            if (k == 3) begin
                tests++; if (ir !== 16'hBEEF) begin fails++; $display("FAIL held_ir_load got %h want beef", ir); end
            end
        end
        tests++; if (reqs !== 1 || dones !== 1) begin fails++; $display("FAIL held_pulses got req=%0d done=%0d want 1/1", reqs, dones); end
        mem_cmd = 2'b00; mem_ready = 1'b0; load_ir = 1'b0; tick();
    endtask

    task automatic test_timeout();
        logic ok = 1'b1;
        addr_sel = 1'b1; mem_cmd = 2'b01; mem_ready = 1'b0;
        tick(); tick();
        for (int k = 0; k < 14; k++) begin
            tick();
            if (bus_err !== 1'b0 || stall !== 1'b1 || mem_done !== 1'b0) ok = 1'b0;
        end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL timeout_early got early err/done/stall drop want none"); end
        tick();
        tests++; if (bus_err !== 1'b1 || mem_done !== 1'b1 || stall !== 1'b0 || read_data !== 16'hBEEF) begin fails++; $display("FAIL timeout_done got err=%b done=%b stall=%b rd=%h want 1/1/0/beef", bus_err, mem_done, stall, read_data); end
        mem_cmd = 2'b00;
        tick(); tick(); tick();
        tests++; if (bus_err !== 1'b1 || mem_done !== 1'b0) begin fails++; $display("FAIL timeout_sticky got err=%b done=%b want 1/0", bus_err, mem_done); end
        reset_pc = 1'b1; tick(); reset_pc = 1'b0;
        tests++; if (bus_err !== 1'b0 || pc !== 9'd0) begin fails++; $display("FAIL timeout_clear got err=%b pc=%0d want 0/0", bus_err, pc); end
    endtask

    task automatic test_wrap();
        load_pc = 1'b1;
        for (int i = 0; i < 511; i++) tick();
        load_pc = 1'b0;
        tests++; if (pc !== 9'd511) begin fails++; $display("FAIL wrap_max got %0d want 511", pc); end
        load_pc = 1'b1; tick();
        tests++; if (pc !== 9'd0) begin fails++; $display("FAIL wrap_zero got %0d want 0", pc); end
        tick(); tick(); tick();
        reset_pc = 1'b1; tick(); reset_pc = 1'b0; load_pc = 1'b0;
        tests++; if (pc !== 9'd0) begin fails++; $display("FAIL wrap_both got %0d want 0", pc); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        load_pc = 1'b1; tick(); load_pc = 1'b0;
        addr_sel = 1'b1; mem_cmd = 2'b01;
        tick();
        tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rstmid_issue got req=%b want 1", mem_req); end
        #2 reset = 1'b0;
        #1;
        tests++; if (mem_req !== 1'b0 || stall !== 1'b0 || pc !== 9'd0) begin fails++; $display("FAIL rstmid_issue_drop got req=%b stall=%b pc=%0d want 0/0/0", mem_req, stall, pc); end
        @(negedge clk) reset = 1'b1;
        tick(); tick();
        tests++; if (stall !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL rstmid_wait got stall=%b req=%b want 1/0", stall, mem_req); end
        #2 reset = 1'b0;
        #1;
        tests++; if (stall !== 1'b0 || mem_req !== 1'b0 || mem_done !== 1'b0) begin fails++; $display("FAIL rstmid_wait_drop got stall=%b req=%b done=%b want 0/0/0", stall, mem_req, mem_done); end
        mem_cmd = 2'b00;
        @(negedge clk) begin reset = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hAAAA; end
        for (int k = 0; k < 5; k++) begin
            tick();
            if (mem_done) dones++;
        end
        tests++; if (dones !== 0 || read_data !== 16'h0) begin fails++; $display("FAIL rstmid_late_ready got done=%0d rd=%h want 0/0000", dones, read_data); end
        mem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; mem_cmd = 2'b00; load_pc = 1'b0; reset_pc = 1'b0; load_ir = 1'b0;
        addr_sel = 1'b0; load_addr = 1'b0; datapath_out = 16'h0; mem_rdata = 16'h0; mem_ready = 1'b0;
        #3;
        test_reset();
        test_fetch();
        test_write();
        test_held_cmd();
        test_timeout();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
